// File: rtl/button_reader.sv
// button_reader: conditions one raw push-button pin into clean, single-cycle
// events in the CLK domain.
//   synchroniser (2 flops) -> counter debouncer -> press-tracking FSM
// Optional feature macro: BTN_REPEAT_EN enables the auto-repeat pulse train
// while the button is held past the long-press point. Without it REPEAT is
// tied low and no repeat counter exists.
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int LONG_CYCLES     = 8000000,
    parameter int REPEAT_CYCLES   = 1600000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN,
    output logic       LEVEL,
    output logic       PRESS,
    output logic       RELEASE,
    output logic       LONG,
    output logic       REPEAT,
    output logic [7:0] PRESS_COUNT
);

    // Debounce counter holds values up to DEBOUNCE_CYCLES and never wraps.
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    // Hold counter only has to reach LONG_CYCLES-1.
    localparam int HOLD_W = $clog2(LONG_CYCLES);

    typedef enum logic [1:0] {
        UP   = 2'd0,
        DOWN = 2'd1,
        HELD = 2'd2
    } state_t;

    logic              btn_in;
    logic              sync_p0;
    logic              sync_p1;
    logic [DB_W-1:0]   db_cnt;
    logic              db_fire;
    logic              level_rise;
    logic              level_fall;
    logic [HOLD_W-1:0] hold_cnt;
    state_t            state;

    // Polarity is normalised before the synchroniser so everything downstream
    // treats 1 as "pressed".
    assign btn_in = ACTIVE_LOW ? ~BTN : BTN;

    // Two-flop metastability guard; reset loads the released level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_in;
            sync_p1 <= sync_p0;
        end
    end

    // The counter must already hold DEBOUNCE_CYCLES and the synchronised level
    // must still disagree before LEVEL flips. The FSM sees this same-cycle
    // decision so PRESS/RELEASE register together with LEVEL.
    assign db_fire    = (sync_p1 != LEVEL) && (db_cnt == DB_W'(DEBOUNCE_CYCLES));
    assign level_rise = db_fire && !LEVEL;
    assign level_fall = db_fire && LEVEL;

    // Debouncer: count consecutive disagreeing samples, toggle LEVEL on terminal count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            db_cnt <= '0;
            LEVEL  <= 1'b0;
        end else if (sync_p1 == LEVEL) begin
            db_cnt <= '0;
        end else if (db_fire) begin
            db_cnt <= '0;
            LEVEL  <= ~LEVEL;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    logic [REP_W-1:0] rep_cnt;
`else
    assign REPEAT = 1'b0;
`endif

    // Press-tracking FSM with registered single-cycle event pulses. Release
    // is tested first so it wins over a coincident LONG/REPEAT terminal count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= UP;
            hold_cnt    <= '0;
            PRESS       <= 1'b0;
            RELEASE     <= 1'b0;
            LONG        <= 1'b0;
            PRESS_COUNT <= 8'd0;
`ifdef BTN_REPEAT_EN
            rep_cnt     <= '0;
            REPEAT      <= 1'b0;
`endif
        end else begin
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            LONG    <= 1'b0;
`ifdef BTN_REPEAT_EN
            REPEAT  <= 1'b0;
`endif
            case (state)
                UP: begin
                    if (level_rise) begin
                        state       <= DOWN;
                        PRESS       <= 1'b1;
                        PRESS_COUNT <= PRESS_COUNT + 8'd1;
                        hold_cnt    <= '0;
                    end
                end
                DOWN: begin
                    if (level_fall) begin
                        state   <= UP;
                        RELEASE <= 1'b1;
                    end else if (hold_cnt == HOLD_W'(LONG_CYCLES - 1)) begin
                        state <= HELD;
                        LONG  <= 1'b1;
`ifdef BTN_REPEAT_EN
                        rep_cnt <= '0;
`endif
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                HELD: begin
                    if (level_fall) begin
                        state   <= UP;
                        RELEASE <= 1'b1;
`ifdef BTN_REPEAT_EN
                        rep_cnt <= '0;
                    end else if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
                        REPEAT  <= 1'b1;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
`endif
                    end
                end
                default: begin
                    state <= UP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: directed scenarios plus randomised pin activity,
// checked cycle by cycle against a window-based behavioural model. A second
// instance with ACTIVE_LOW=1 sees the inverted pin and must behave identically.
module tb_button_reader;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       btn_n;
    logic       a_level, a_press, a_release, a_long, a_repeat;
    logic [7:0] a_count;
    logic       b_level, b_press, b_release, b_long, b_repeat;
    logic [7:0] b_count;

    always #5 clk = ~clk;
    assign btn_n = ~btn;

    button_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .ACTIVE_LOW(1'b0)) dut_a (
        .CLK(clk), .RST(rst), .BTN(btn), .LEVEL(a_level), .PRESS(a_press), .RELEASE(a_release),
        .LONG(a_long), .REPEAT(a_repeat), .PRESS_COUNT(a_count));

    button_reader #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .ACTIVE_LOW(1'b1)) dut_b (
        .CLK(clk), .RST(rst), .BTN(btn_n), .LEVEL(b_level), .PRESS(b_press), .RELEASE(b_release),
        .LONG(b_long), .REPEAT(b_repeat), .PRESS_COUNT(b_count));

    int checks = 0;
    int errors = 0;
    int k = -1;

    // Model state: pressed-level history as sampled at each edge, plus event bookkeeping.
    bit s [0:32767];
    bit m_level, m_press, m_release, m_long, m_repeat, m_long_done;
    int m_count, t_press;

    // Events observed on the ACTIVE_LOW=0 instance.
    int last_press = -1, last_release = -1, last_long = -1;
    int n_press = 0, n_release = 0, n_long = 0;
    int rep_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (edge %0d)", tag, got, exp, k);
        end
    endtask

    // One clock edge of the reference: LEVEL flips when the pin value sampled
    // over the D+1 edges ending two edges ago all disagree with it; events follow
    // from the time elapsed since the press.
    task automatic model_edge();
        bit toggle;
        int d;
        k++;
        m_press = 0; m_release = 0; m_long = 0; m_repeat = 0;
        if (rst) begin
            s[k] = 1'b0;
            if (k > 0) s[k-1] = 1'b0;
            m_level = 0; m_count = 0; m_long_done = 0;
        end else begin
            s[k] = btn;
            toggle = (k - 2 - D >= 0);
            for (int j = k - 2 - D; j <= k - 2 && toggle; j++)
                if (j >= 0 && s[j] == m_level) toggle = 0;
            if (toggle) begin
                m_level = !m_level;
                if (m_level) begin
                    m_press = 1; m_count = (m_count + 1) % 256;
                    t_press = k; m_long_done = 0;
                end else begin
                    m_release = 1;
                end
            end else if (m_level) begin
                d = k - t_press;
                if (!m_long_done && d == L) begin
                    m_long = 1; m_long_done = 1;
                end
`ifdef BTN_REPEAT_EN
                else if (m_long_done && d > L && ((d - L) % R) == 0) begin
                    m_repeat = 1;
                end
`endif
            end
        end
    endtask

    task automatic compare();
        check("a_level",   a_level,   m_level);
        check("a_press",   a_press,   m_press);
        check("a_release", a_release, m_release);
        check("a_long",    a_long,    m_long);
        check("a_repeat",  a_repeat,  m_repeat);
        check("a_count",   a_count,   m_count);
        check("b_level",   b_level,   m_level);
        check("b_press",   b_press,   m_press);
        check("b_release", b_release, m_release);
        check("b_long",    b_long,    m_long);
        check("b_repeat",  b_repeat,  m_repeat);
        check("b_count",   b_count,   m_count);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        if (a_press === 1'b1)   begin last_press = k;   n_press++;   end
        if (a_release === 1'b1) begin last_release = k; n_release++; end
        if (a_long === 1'b1)    begin last_long = k;    n_long++;    end
        if (a_repeat === 1'b1)  rep_q.push_back(k);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int es, p, n0, nl0, nr0, nrep, first;
        rst = 1'b1;
        btn = 1'b0;

        // Reset state
        ticks(3);
        check("rst_level", a_level, 0);
        check("rst_count", a_count, 0);
        rst = 1'b0;
        ticks(3);

        // Clean press
        btn = 1'b1; es = k + 1;
        ticks(12);
        check("clean_lat", last_press - es, 6);
        check("clean_cnt", a_count, 1);
        btn = 1'b0;
        ticks(12);

        // Bounce then settle
        n0 = n_press;
        for (int i = 0; i < 8; i++) begin
            btn = ((i / 2) % 2 == 0);
            tick();
        end
        check("bounce_quiet", n_press - n0, 0);
        btn = 1'b1; es = k + 1;
        ticks(12);
        check("bounce_npress", n_press - n0, 1);
        check("bounce_lat", last_press - es, 6);
        btn = 1'b0;
        ticks(12);

        // Long press with repeat
        btn = 1'b1; es = k + 1;
        ticks(7);
        p = k;
        check("long_press", last_press, p);
        rep_q.delete();
        n0 = n_release;
        ticks(60);
        check("long_lat", last_long - p, L);
        nrep = 0;
        foreach (rep_q[i]) if (rep_q[i] <= p + 52) nrep++;
        first = (rep_q.size() > 0) ? rep_q[0] - p : -1;
`ifdef BTN_REPEAT_EN
        check("rep_first", first, 28);
        check("rep_count", nrep, 4);
`else
        check("rep_none", rep_q.size(), 0);
`endif
        btn = 1'b0;
        ticks(12);
        check("long_rel", n_release - n0, 1);

        // Release racing the long-press terminal count
        btn = 1'b1; es = k + 1;
        ticks(7);
        p = k;
        check("race_press", last_press, es + 6);
        nl0 = n_long;
        ticks(13);
        btn = 1'b0;
        ticks(12);
        check("race_rel", last_release - p, 20);
        check("race_nolong", n_long - nl0, 0);
        check("race_level", a_level, 0);

        // Reset in the middle of a hold
        btn = 1'b1; es = k + 1;
        ticks(7);
        p = k;
        ticks(9);
        rst = 1'b1;
        ticks(1);
        check("rstmid_cnt", a_count, 0);
        check("rstmid_level", a_level, 0);
        rst = 1'b0;
        ticks(8);
        check("rstmid_lat", last_press - p, 17);
        check("rstmid_cnt1", a_count, 1);
        btn = 1'b0;
        ticks(12);

        // Random pin activity with occasional resets
        for (int i = 0; i < 150; i++) begin
            btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            ticks($urandom_range(1, 30));
        end

        // Counter wrap after 256 presses
        rst = 1'b1; btn = 1'b0;
        ticks(1);
        rst = 1'b0;
        ticks(3);
        n0 = n_press;
        for (int i = 0; i < 256; i++) begin
            btn = 1'b1; ticks(8);
            btn = 1'b0; ticks(8);
        end
        ticks(4);
        check("wrap_npress", n_press - n0, 256);
        check("wrap_cnt_a", a_count, 0);
        check("wrap_cnt_b", b_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
